// File: rtl/phy_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one PHY transmit path among N_REQ router ports.
// Flits are only offered while the credit mirror of the PHY input buffer is non-zero.
module phy_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int FLIT_W  = 18,
    parameter int CREDITS = 30,
    parameter int TIMEOUT = 64,
    localparam int CNT_W  = $clog2(CREDITS + 1),
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                      CLK,
    input  logic                      rst_n,
    input  logic [N_REQ*FLIT_W-1:0]   req_flit,
    output logic [N_REQ-1:0]          req_ready,
    output logic [FLIT_W-1:0]         phy_flit,
    output logic                      en_send_to_phy,
    input  logic                      credit_ret,
    output logic [CNT_W-1:0]          credit_cnt,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      err
);

    // state | meaning
    // IDLE  | no owner; round-robin scan from r_rr_ptr picks the next owner
    // XFER  | owner locked until its tail flit is accepted or the idle timeout fires
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [0:0]        r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_grant_id;
    logic [CNT_W-1:0]  r_credit;
    logic [FLIT_W-1:0] r_phy_flit;
    logic              r_en;
    logic              r_err;
    logic [TO_W-1:0]   r_idle_cnt;

    logic [N_REQ-1:0]  w_valid;
    logic [FLIT_W-1:0] w_owner_flit;
    logic              w_owner_valid;
    logic              w_owner_tail;
    logic              w_xfer;
    logic              w_credit_ok;
    logic              w_accept;
    logic              w_win_found;
    logic [ID_W-1:0]   w_win_id;
    logic [ID_W:0]     w_scan_idx;
    logic [ID_W-1:0]   w_next_ptr;

    always_comb begin
        w_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_valid[i] = req_flit[i*FLIT_W + FLIT_W - 1];
        end
    end

    always_comb begin
        w_owner_flit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant_id == ID_W'(i)) begin
                w_owner_flit = req_flit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    // Scan downward so the last hit, i.e. the closest to r_rr_ptr, wins.
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        w_scan_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_scan_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_scan_idx >= (ID_W+1)'(N_REQ)) begin
                w_scan_idx = w_scan_idx - (ID_W+1)'(N_REQ);
            end
            if (w_valid[w_scan_idx[ID_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_id    = w_scan_idx[ID_W-1:0];
            end
        end
    end

    assign w_owner_valid = w_owner_flit[FLIT_W-1];
    assign w_owner_tail  = w_owner_flit[FLIT_W-2];
    assign w_xfer        = (r_state == ST_XFER);
    assign w_credit_ok   = (r_credit != '0);
    assign w_accept      = w_xfer && w_credit_ok && w_owner_valid;
    assign w_next_ptr    = (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

    always_comb begin
        req_ready = '0;
        if (w_xfer && w_credit_ok) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_credit   <= CNT_W'(CREDITS);
            r_phy_flit <= '0;
            r_en       <= 1'b0;
            r_err      <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            r_phy_flit <= w_accept ? w_owner_flit : '0;
            r_en       <= w_accept;

            // A return coinciding with an accept cancels out; a return at full is an overflow.
            if (credit_ret && !w_accept) begin
                if (r_credit == CNT_W'(CREDITS)) begin
                    r_err <= 1'b1;
                end else begin
                    r_credit <= r_credit + CNT_W'(1);
                end
            end else if (w_accept && !credit_ret) begin
                r_credit <= r_credit - CNT_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    r_idle_cnt <= '0;
                    if (w_win_found) begin
                        r_grant_id <= w_win_id;
                        r_state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_accept) begin
                        r_idle_cnt <= '0;
                        if (w_owner_tail) begin
                            r_state  <= ST_IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end else if (!w_owner_valid) begin
                        if (r_idle_cnt == TO_W'(TIMEOUT - 1)) begin
                            r_err      <= 1'b1;
                            r_state    <= ST_IDLE;
                            r_rr_ptr   <= w_next_ptr;
                            r_idle_cnt <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + TO_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign phy_flit       = r_phy_flit;
    assign en_send_to_phy = r_en;
    assign credit_cnt     = r_credit;
    assign grant_id       = r_grant_id;
    assign busy           = w_xfer;
    assign err            = r_err;

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Bench for phy_tx_arbiter: per-requester flit queues drive the DUT, accepted flits go to a
// scoreboard queue and are checked against phy_flit one cycle later.
module tb_phy_tx_arbiter;

    localparam int N_REQ   = 4;
    localparam int FLIT_W  = 18;
    localparam int CREDITS = 30;
    localparam int TIMEOUT = 64;

    logic                    CLK = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N_REQ*FLIT_W-1:0] req_flit = '0;
    logic                    credit_ret = 1'b0;
    logic [N_REQ-1:0]        req_ready;
    logic [FLIT_W-1:0]       phy_flit;
    logic                    en_send_to_phy;
    logic [4:0]              credit_cnt;
    logic [1:0]              grant_id;
    logic                    busy;
    logic                    err;

    phy_tx_arbiter #(
        .N_REQ(N_REQ), .FLIT_W(FLIT_W), .CREDITS(CREDITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .req_flit(req_flit), .req_ready(req_ready),
        .phy_flit(phy_flit), .en_send_to_phy(en_send_to_phy), .credit_ret(credit_ret),
        .credit_cnt(credit_cnt), .grant_id(grant_id), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int                req;
        logic [FLIT_W-1:0] flit;
        int                exp_grant;
    } rr_vec_t;

    int                n_vec = 0;
    int                n_miss = 0;
    int                cyc = 0;
    int                model_cred = CREDITS;
    logic              prev_busy = 1'b0;
    logic [FLIT_W-1:0] src_q [N_REQ][$];
    logic [FLIT_W-1:0] scb_q [$];
    int                en_cycles [$];
    int                obs_grants [$];
    rr_vec_t           rr_tbl [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [FLIT_W-1:0] mk(input logic tail, input int tag);
        logic [15:0] t;
        t = tag[15:0];
        return {1'b1, tail, t};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_phy_flit"},  64'(phy_flit), 64'(0));
        check({tag, "_en"},        64'(en_send_to_phy), 64'(0));
        check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_grant_id"},  64'(grant_id), 64'(0));
        check({tag, "_busy"},      64'(busy), 64'(0));
        check({tag, "_err"},       64'(err), 64'(0));
        check({tag, "_credit"},    64'(credit_cnt), 64'(CREDITS));
    endtask

    // One clock: check the previous edge's outputs, then drive inputs for the next edge.
    task automatic step(input logic ret);
        logic [FLIT_W-1:0] exp_f;
        logic              acc;
        @(negedge CLK);
        cyc++;
        if (scb_q.size() > 0) begin
            exp_f = scb_q.pop_front();
            check("phy_en", 64'(en_send_to_phy), 64'(1));
            check("phy_flit", 64'(phy_flit), 64'(exp_f));
        end else begin
            check("phy_idle_en", 64'(en_send_to_phy), 64'(0));
            check("phy_idle_flit", 64'(phy_flit), 64'(0));
        end
        if (en_send_to_phy) en_cycles.push_back(cyc);
        check("credit_cnt", 64'(credit_cnt), 64'(model_cred));
        check("ready_onehot", 64'($countones(req_ready) <= 1), 64'(1));
        if (busy && !prev_busy) obs_grants.push_back(int'(grant_id));
        prev_busy = busy;

        credit_ret = ret;
        acc = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (src_q[i].size() > 0) req_flit[i*FLIT_W +: FLIT_W] = src_q[i][0];
            else                     req_flit[i*FLIT_W +: FLIT_W] = '0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i] && src_q[i].size() > 0) begin
                scb_q.push_back(src_q[i].pop_front());
                acc = 1'b1;
            end
        end
        if (ret && !acc) begin
            if (model_cred < CREDITS) model_cred++;
        end else if (acc && !ret) begin
            model_cred--;
        end
    endtask

    task automatic do_reset(input bit mid);
        if (mid) begin
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midrst");
        end
        rst_n      = 1'b0;
        req_flit   = '0;
        credit_ret = 1'b0;
        for (int i = 0; i < N_REQ; i++) src_q[i].delete();
        scb_q.delete();
        en_cycles.delete();
        obs_grants.delete();
        model_cred = CREDITS;
        prev_busy  = 1'b0;
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
    endtask

    initial begin
        int start;

        // Reset values
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Three-flit packet from requester 0
        src_q[0].push_back(mk(1'b0, 16'h101));
        src_q[0].push_back(mk(1'b0, 16'h102));
        src_q[0].push_back(mk(1'b1, 16'h103));
        start = cyc;
        repeat (8) step(1'b0);
        check("pkt3_flits", 64'(en_cycles.size()), 64'(3));
        if (en_cycles.size() == 3) begin
            check("pkt3_lat0", 64'(en_cycles[0] - start), 64'(3));
            check("pkt3_lat2", 64'(en_cycles[2] - start), 64'(5));
        end
        check("pkt3_grants", 64'(obs_grants.size()), 64'(1));
        if (obs_grants.size() > 0) check("pkt3_grant_id", 64'(obs_grants[0]), 64'(0));
        check("pkt3_credit", 64'(credit_cnt), 64'(27));
        check("pkt3_idle", 64'(busy), 64'(0));

        // Round robin over single-flit packets
        do_reset(1'b0);
        rr_tbl[0] = '{req: 0, flit: mk(1'b1, 16'h200), exp_grant: 0};
        rr_tbl[1] = '{req: 1, flit: mk(1'b1, 16'h201), exp_grant: 1};
        rr_tbl[2] = '{req: 2, flit: mk(1'b1, 16'h202), exp_grant: 2};
        rr_tbl[3] = '{req: 3, flit: mk(1'b1, 16'h203), exp_grant: 3};
        rr_tbl[4] = '{req: 0, flit: mk(1'b1, 16'h204), exp_grant: 0};
        for (int k = 0; k < 5; k++) src_q[rr_tbl[k].req].push_back(rr_tbl[k].flit);
        repeat (14) step(1'b0);
        check("rr_grant_count", 64'(obs_grants.size()), 64'(5));
        for (int k = 0; k < 5; k++) begin
            if (k < obs_grants.size()) check("rr_grant", 64'(obs_grants[k]), 64'(rr_tbl[k].exp_grant));
        end
        check("rr_flit_count", 64'(en_cycles.size()), 64'(5));
        for (int k = 1; k < 5; k++) begin
            if (k < en_cycles.size()) check("rr_bubble", 64'(en_cycles[k] - en_cycles[k-1]), 64'(2));
        end

        // Credit exhaustion with requester 1 streaming
        do_reset(1'b0);
        for (int k = 0; k < 32; k++) src_q[1].push_back(mk(1'b0, 16'h300 + k));
        repeat (40) step(1'b0);
        check("cred_accepts", 64'(en_cycles.size()), 64'(30));
        check("cred_zero", 64'(credit_cnt), 64'(0));
        check("cred_ready_low", 64'(req_ready), 64'(0));
        check("cred_hold_busy", 64'(busy), 64'(1));
        check("cred_hold_grant", 64'(grant_id), 64'(1));
        step(1'b1);
        repeat (6) step(1'b0);
        check("cred_one_more", 64'(en_cycles.size()), 64'(31));
        check("cred_zero_again", 64'(req_ready), 64'(0));

        // Return coinciding with an accept leaves the count unchanged
        src_q[1].push_back(mk(1'b1, 16'h321));
        step(1'b1);
        step(1'b1);
        step(1'b0);
        check("cred_ret_accept_cnt", 64'(credit_cnt), 64'(1));
        check("cred_ret_accept_en", 64'(en_sent_now()), 64'(1));

        // Return at full credit saturates and sets err
        do_reset(1'b0);
        step(1'b0);
        check("ovf_err_before", 64'(err), 64'(0));
        step(1'b1);
        step(1'b0);
        check("ovf_credit", 64'(credit_cnt), 64'(CREDITS));
        check("ovf_err", 64'(err), 64'(1));

        // Mid-packet idle timeout from requester 2, requester 3 waiting
        do_reset(1'b0);
        src_q[2].push_back(mk(1'b0, 16'h500));
        src_q[3].push_back(mk(1'b1, 16'h600));
        repeat (2) step(1'b0);
        repeat (TIMEOUT) step(1'b0);
        check("to_err_early", 64'(err), 64'(0));
        check("to_busy_early", 64'(busy), 64'(1));
        step(1'b0);
        check("to_err", 64'(err), 64'(1));
        check("to_idle", 64'(busy), 64'(0));
        step(1'b0);
        check("to_next_busy", 64'(busy), 64'(1));
        check("to_next_grant", 64'(grant_id), 64'(3));
        if (obs_grants.size() > 0) check("to_first_grant", 64'(obs_grants[0]), 64'(2));
        repeat (3) step(1'b0);

        // Reset in the middle of requester 2's packet after rr pointer has moved
        src_q[1].push_back(mk(1'b1, 16'h701));
        src_q[2].push_back(mk(1'b0, 16'h702));
        src_q[2].push_back(mk(1'b0, 16'h703));
        src_q[2].push_back(mk(1'b0, 16'h704));
        repeat (5) step(1'b0);
        check("pre_rst_busy", 64'(busy), 64'(1));
        check("pre_rst_grant", 64'(grant_id), 64'(2));
        do_reset(1'b1);
        src_q[3].push_back(mk(1'b1, 16'h803));
        src_q[0].push_back(mk(1'b1, 16'h800));
        repeat (4) step(1'b0);
        check("post_rst_grants", 64'(obs_grants.size() > 0), 64'(1));
        if (obs_grants.size() > 0) check("post_rst_first", 64'(obs_grants[0]), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    function automatic logic en_sent_now();
        return en_send_to_phy;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
